// File: rtl/fetch_pkg.sv
// Shared widths, fetch state encoding and the skid word layout for the instruction fetch unit.
// The optional skid buffer is enabled with the FETCH_SKID_BUFFER_EN macro.
package fetch_pkg;

    localparam int ADDR_W     = 6;
    localparam int INST_W     = 32;
    localparam int IMEM_DEPTH = 64;
    localparam int SKID_W     = ADDR_W + INST_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_BUBBLE,
        FETCH_HOLD
    } fetch_state_t;

    // Word parked while decode stalls: the address travels with its instruction.
    typedef struct packed {
        addr_t pc;
        inst_t instruction;
    } fetch_word_t;

    // Word addresses wrap naturally at the top of the 64-entry memory.
    function automatic addr_t pc_increment(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding register for a fetched word that decode could not accept.
// Instantiated by instruction_fetch_unit only when FETCH_SKID_BUFFER_EN is defined.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture,
    input  logic        consume,
    input  fetch_word_t word_in,
    output logic        occupied,
    output fetch_word_t word_out
);

    logic        skid_valid_reg;
    fetch_word_t skid_word_reg;

    // A redirect drops the parked word just like a reset does.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            skid_valid_reg <= 1'b0;
            skid_word_reg  <= '0;
        end else if (capture) begin
            skid_valid_reg <= 1'b1;
            skid_word_reg  <= word_in;
        end else if (consume) begin
            skid_valid_reg <= 1'b0;
        end
    end

    assign occupied = skid_valid_reg;
    assign word_out = skid_word_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch with redirect squash and decode back-pressure.
// Default build replays a stalled word; FETCH_SKID_BUFFER_EN parks it in a skid register instead.
module instruction_fetch_unit
    import fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [INST_W-1:0] imem_instruction,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              fetch_valid,
    output logic [INST_W-1:0] fetch_instruction,
    output logic [ADDR_W-1:0] fetch_pc
);

    addr_t        pc_reg;
    addr_t        inflight_pc_reg;
    logic         inflight_valid_reg;
    fetch_state_t fetch_state;

`ifdef FETCH_SKID_BUFFER_EN
    logic        skid_occupied;
    fetch_word_t skid_word;
    fetch_word_t capture_word;
    logic        skid_capture;
    logic        skid_consume;

    assign capture_word.pc          = inflight_pc_reg;
    assign capture_word.instruction = imem_instruction;

    // Only a live word with an empty skid is captured; redirect always wins.
    assign skid_capture = !redirect_valid && stall && inflight_valid_reg && !skid_occupied;
    assign skid_consume = !redirect_valid && !stall && skid_occupied;

    fetch_skid_buffer u_skid (
        .clock    (clock),
        .reset    (reset),
        .clear    (redirect_valid),
        .capture  (skid_capture),
        .consume  (skid_consume),
        .word_in  (capture_word),
        .occupied (skid_occupied),
        .word_out (skid_word)
    );
`endif

    always_comb begin
        fetch_state = FETCH_BUBBLE;
`ifdef FETCH_SKID_BUFFER_EN
        if (skid_occupied) begin
            fetch_state = FETCH_HOLD;
        end else if (inflight_valid_reg) begin
            fetch_state = FETCH_RUN;
        end
`else
        if (inflight_valid_reg) begin
            fetch_state = FETCH_RUN;
        end
`endif
    end

    // The memory read is registered, so pc is the address of the word that
    // becomes inflight on the next edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg             <= '0;
            inflight_pc_reg    <= '0;
            inflight_valid_reg <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg             <= redirect_target;
            inflight_valid_reg <= 1'b0;
        end else if (stall) begin
            inflight_valid_reg <= 1'b0;
`ifndef FETCH_SKID_BUFFER_EN
            // Rewind so the dropped word is fetched again after the stall.
            if (fetch_state == FETCH_RUN) begin
                pc_reg <= inflight_pc_reg;
            end
`endif
        end else begin
            pc_reg             <= pc_increment(pc_reg);
            inflight_pc_reg    <= pc_reg;
            inflight_valid_reg <= 1'b1;
        end
    end

    assign imem_address = pc_reg;
    assign fetch_valid  = (fetch_state != FETCH_BUBBLE);

`ifdef FETCH_SKID_BUFFER_EN
    assign fetch_instruction = (fetch_state == FETCH_HOLD) ? skid_word.instruction : imem_instruction;
    assign fetch_pc          = (fetch_state == FETCH_HOLD) ? skid_word.pc : inflight_pc_reg;
`else
    assign fetch_instruction = imem_instruction;
    assign fetch_pc          = inflight_pc_reg;
`endif

endmodule
